// File: rtl/nand_decoder_if.sv
// ---------------------------------------------------------------------------
// nand_decoder_if
//   Groups the select inputs and the decoded, registered outputs of the
//   2-to-4 active-low decoder into one bundle.
//
//   Signals:
//     en     decode enable, active-high        (master -> slave)
//     a      select MSB                        (master -> slave)
//     b      select LSB                        (master -> slave)
//     d0..d3 active-low decoded lines          (slave  -> master)
//     valid  registered copy of en             (slave  -> master)
//
//   Modports:
//     master : drives the select inputs and observes the decoded lines.
//     slave  : the decoder side, which samples the selects and drives the lines.
// ---------------------------------------------------------------------------
interface nand_decoder_if;
  logic en;
  logic a;
  logic b;
  logic d0;
  logic d1;
  logic d2;
  logic d3;
  logic valid;

  modport master (
    output en,
    output a,
    output b,
    input  d0,
    input  d1,
    input  d2,
    input  d3,
    input  valid
  );

  modport slave (
    input  en,
    input  a,
    input  b,
    output d0,
    output d1,
    output d2,
    output d3,
    output valid
  );
endinterface : nand_decoder_if

// File: rtl/nand_decoder.sv
// ---------------------------------------------------------------------------
// nand_decoder
//   2-to-4 line decoder with active-low outputs and an active-high enable,
//   built from NAND gates in the style of the 74x139. The decoded lines and
//   a copy of the enable are registered, so consumers see glitch-free outputs
//   that change only on the rising clock edge, one cycle after the inputs are
//   sampled.
//
//   Ports:
//     clk    system clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset; drives every line inactive (high)
//            and valid low, with priority over all other inputs
//     bus    nand_decoder_if.slave
//              en, a, b      : enable and select index {a,b} (a is the MSB)
//              d0..d3        : active-low lines, d<i> low for {a,b} == i
//              valid         : registered en, aligned with d0..d3
// ---------------------------------------------------------------------------
module nand_decoder (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_decoder_if.slave        bus
);

  // Decode stage nets: inverted selects and the four NAND terms.
  logic na_s;
  logic nb_s;
  logic n0_s;
  logic n1_s;
  logic n2_s;
  logic n3_s;

  // Inverters are NANDs with both inputs tied together, keeping the
  // decode stage NAND-only.
  nand u_nand_na (na_s, bus.a, bus.a);
  nand u_nand_nb (nb_s, bus.b, bus.b);

  // Each line NAND goes low only when en is high and its select pattern
  // matches; with en low every term is forced high.
  nand u_nand_n0 (n0_s, na_s,  nb_s,  bus.en);
  nand u_nand_n1 (n1_s, na_s,  bus.b, bus.en);
  nand u_nand_n2 (n2_s, bus.a, nb_s,  bus.en);
  nand u_nand_n3 (n3_s, bus.a, bus.b, bus.en);

  // Register stage state: bit i holds line d<i>.
  logic [3:0] d_d;
  logic [3:0] d_q;
  logic       valid_d;
  logic       valid_q;

  // Next-state: pass the NAND terms and the enable straight to the register.
  always_comb begin
    d_d     = 4'b1111;
    valid_d = 1'b0;
    d_d     = {n3_s, n2_s, n1_s, n0_s};
    valid_d = bus.en;
  end

  // Output register with synchronous active-low reset to all lines inactive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q     <= 4'b1111;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      valid_q <= valid_d;
    end
  end

  assign bus.d0    = d_q[0];
  assign bus.d1    = d_q[1];
  assign bus.d2    = d_q[2];
  assign bus.d3    = d_q[3];
  assign bus.valid = valid_q;

endmodule : nand_decoder

// File: tb/tb_nand_decoder.sv
// ---------------------------------------------------------------------------
// tb_nand_decoder
//   Scoreboard bench for nand_decoder. The driver applies one input set per
//   cycle on the falling edge and pushes the expected registered response
//   {valid, d0, d1, d2, d3} into a queue; the monitor pops one entry per
//   rising edge (sampled 1 time unit after the edge) and compares.
// ---------------------------------------------------------------------------
module tb_nand_decoder;

  logic clk;
  logic rst_n;

  nand_decoder_if bus ();

  nand_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected response, packed as {valid, d0, d1, d2, d3}.
  logic [4:0] exp_q [$];
  logic [4:0] last_exp;

  // Reference model for the random phase: independent of the gate network.
  function automatic logic [4:0] model(input logic r, input logic e,
                                       input logic aa, input logic bb);
    logic [3:0] lines;
    logic [1:0] idx;
    idx = {aa, bb};
    if (!r || !e) begin
      lines = 4'b1111;
    end else begin
      lines = 4'b1111 & ~(4'b1000 >> idx);
    end
    return {r & e, lines};
  endfunction

  // Apply one cycle of stimulus and queue its expected response.
  task automatic step(input logic r, input logic e, input logic aa,
                      input logic bb, input logic [4:0] exp_v);
    @(negedge clk);
    rst_n  = r;
    bus.en = e;
    bus.a  = aa;
    bus.b  = bb;
    exp_q.push_back(exp_v);
    last_exp = exp_v;
  endtask

  // Glitch cycle: selects toggle several times between edges and settle at
  // {a,b}; outputs must still show the previous cycle's value just before
  // the edge.
  task automatic glitch_step(input logic aa, input logic bb,
                             input logic [4:0] exp_v);
    logic [4:0] prev;
    prev = last_exp;
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    bus.a = 1'b0; bus.b = 1'b0; #1;
    bus.a = 1'b1;               #1;
    bus.b = 1'b1;               #1;
    bus.a = 1'b0; bus.b = 1'b0; #0.5;
    bus.a = aa;   bus.b = bb;   #0.5;
    total++;
    if ({bus.valid, bus.d0, bus.d1, bus.d2, bus.d3} !== prev) begin
      bad++;
      $display("FAIL hold_between_edges got=%b exp=%b",
               {bus.valid, bus.d0, bus.d1, bus.d2, bus.d3}, prev);
    end
    exp_q.push_back(exp_v);
    last_exp = exp_v;
  endtask

  // Monitor: one registered response per rising edge while entries remain.
  initial begin
    logic [4:0] got;
    logic [4:0] exp_v;
    int         lows;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        got   = {bus.valid, bus.d0, bus.d1, bus.d2, bus.d3};
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL outputs got=%b exp=%b (valid,d0..d3)", got, exp_v);
        end
        lows = 0;
        for (int i = 0; i < 4; i++) begin
          if (got[i] === 1'b0) lows++;
        end
        total++;
        if (lows != int'(exp_v[4])) begin
          bad++;
          $display("FAIL one_hot got_lows=%0d exp_lows=%0d", lows, int'(exp_v[4]));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic r, e, aa, bb;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.a  = 1'b0;
    bus.b  = 1'b0;
    last_exp = 5'b0_1111;

    // Reset for two cycles with en=1, {a,b}=11.
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'b0_1111);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'b0_1111);

    // Exhaustive decode.
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'b1_0111);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'b1_1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'b1_1101);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'b1_1110);

    // Enable low for every select, then re-enable with {a,b}=10.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'b0_1111);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'b0_1111);
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'b0_1111);
    step(1'b1, 1'b0, 1'b1, 1'b1, 5'b0_1111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'b1_1101);

    // Glitchy selects settling at 01.
    glitch_step(1'b0, 1'b1, 5'b1_1011);

    // Mid-run reset while decoding 11, then release with 00.
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'b1_1110);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'b0_1111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'b1_0111);

    // Random enable/select sequence checked against the reference model.
    for (int k = 0; k < 1000; k++) begin
      r  = 1'b1;
      e  = 1'($urandom_range(0, 1));
      aa = 1'($urandom_range(0, 1));
      bb = 1'($urandom_range(0, 1));
      step(r, e, aa, bb, model(r, e, aa, bb));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 5 && exp_q.size() != 0; w++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nand_decoder
